// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_rsp_state_t;

    localparam int unsigned WORD_OFFSET_BITS = 2;

endpackage : mem_responder_pkg

// File: rtl/mem_responder_array.sv
// Word storage with byte-masked write and a registered read port.
// Both ports act on the request-accept edge.
module mem_responder_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_SIZE   = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_i,
    input  logic                          we_i,
    input  logic                          zero_rd_i,
    input  logic [$clog2(MEM_SIZE)-1:0]   idx_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic [DATA_WIDTH/8-1:0]       wstrb_i,
    output logic [DATA_WIDTH-1:0]         rdata_o
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage is deliberately not reset so committed stores survive rst.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Read register doubles as the response data register; stores and errors return 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= zero_rd_i ? '0 : mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : mem_responder_array

// File: rtl/mem_responder.sv
// Handshaked data-memory responder: one outstanding request, fixed LATENCY response.
// Optional feature macro: MEM_RESPONDER_MISALIGN_ERR_EN (misaligned access -> rsp_err).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_SIZE   = 1024,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic                      req_we,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err
);

    localparam int unsigned IDX_W = $clog2(MEM_SIZE);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    mem_rsp_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic             accept_c;
    logic             misalign_c;
    logic [IDX_W-1:0] idx_c;
    logic             addr_unused;

    assign accept_c = req_valid && req_ready_q;
    assign idx_c    = req_addr[IDX_W+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS];

    // Upper address bits alias; low bits only matter with the misalign check.
    assign addr_unused = ^{req_addr[ADDR_WIDTH-1:IDX_W+WORD_OFFSET_BITS],
                           req_addr[WORD_OFFSET_BITS-1:0]};

`ifdef MEM_RESPONDER_MISALIGN_ERR_EN
    assign misalign_c = |req_addr[WORD_OFFSET_BITS-1:0];
`else
    assign misalign_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
            if (accept_c) begin
                rsp_err_q <= misalign_c;
            end
        end
    end

    mem_responder_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_SIZE   (MEM_SIZE)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .en_i      (accept_c),
        .we_i      (accept_c && req_we && !misalign_c),
        .zero_rd_i (req_we || misalign_c),
        .idx_i     (idx_c),
        .wdata_i   (req_wdata),
        .wstrb_i   (req_wstrb),
        .rdata_o   (rsp_rdata)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed steps then random traffic vs a word-array model.
module tb_mem_responder;

    localparam int unsigned LAT = 2;
    localparam int unsigned MSZ = 1024;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int tests  = 0;
    int failed = 0;

    logic [31:0] mem_m [MSZ];
    logic [31:0] last_rdata;

    mem_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .MEM_SIZE   (MSZ),
        .LATENCY    (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: word-indexed array, byte-lane merge, 0 data for stores/errors.
    task automatic model(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] wstrb, output logic [31:0] exp_d, output logic exp_e);
        int idx;
        idx   = int'((addr / 4) % MSZ);
        exp_e = 1'b0;
`ifdef MEM_RESPONDER_MISALIGN_ERR_EN
        exp_e = (addr % 4) != 0;
`endif
        exp_d = 32'h0;
        if (!exp_e) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) mem_m[idx][b*8 +: 8] = wdata[b*8 +: 8];
            end else begin
                exp_d = mem_m[idx];
            end
        end
    endtask

    // One full transaction, starting and ending at a negedge.
    task automatic xact(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int stall, input bit hold_valid);
        logic [31:0] exp_d;
        logic        exp_e;
        int          n;
        int          lat;
        req_valid = 1'b1;
        req_addr  = addr;
        req_we    = we;
        req_wdata = wdata;
        req_wstrb = wstrb;
        rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 64'(n >= 50), 64'(0));
        @(posedge clk);
        model(addr, we, wdata, wstrb, exp_d, exp_e);
        @(negedge clk);
        if (!hold_valid) req_valid = 1'b0;
        req_addr  = $urandom;
        req_we    = 1'($urandom);
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            chk("ready_low_wait", 64'(req_ready), 64'(0));
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(LAT));
        for (int k = 0; k < stall; k++) begin
            chk("stall_valid", 64'(rsp_valid), 64'(1));
            chk("stall_rdata", 64'(rsp_rdata), 64'(exp_d));
            chk("stall_ready", 64'(req_ready), 64'(0));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        chk("rsp_valid", 64'(rsp_valid), 64'(1));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_d));
        chk("rsp_err", 64'(rsp_err), 64'(exp_e));
        last_rdata = rsp_rdata;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_valid", 64'(rsp_valid), 64'(0));
        chk("post_ready", 64'(req_ready), 64'(1));
        req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_d;
        logic        exp_e;
        logic [31:0] a;
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
        req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0; last_rdata = '0;

        // Step 1: reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'(1));
        chk("rst_valid", 64'(rsp_valid), 64'(0));
        chk("rst_err", 64'(rsp_err), 64'(0));
        chk("rst_rdata", 64'(rsp_rdata), 64'(0));

        // Step 2: full store then load
        xact(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        chk("store_rdata_zero", 64'(last_rdata), 64'(0));
        xact(32'h10, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        chk("load_deadbeef", 64'(last_rdata), 64'(32'hDEADBEEF));

        // Step 3: byte-0 partial store
        xact(32'h10, 1'b1, 32'h000000AA, 4'b0001, 0, 1'b0);
        xact(32'h10, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        chk("load_deadbeaa", 64'(last_rdata), 64'(32'hDEADBEAA));

        // Step 4: stalled response with req_valid held high
        xact(32'h10, 1'b0, 32'h0, 4'h0, 5, 1'b1);
        chk("stall_load", 64'(last_rdata), 64'(32'hDEADBEAA));

        // Zero strobe store leaves word unchanged
        xact(32'h10, 1'b1, 32'h12345678, 4'h0, 0, 1'b0);
        xact(32'h10, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        chk("wstrb_zero", 64'(last_rdata), 64'(32'hDEADBEAA));

        // Step 5: aliasing
        xact(32'h0, 1'b1, 32'h55, 4'hF, 0, 1'b0);
        xact(32'h1000, 1'b1, 32'h55, 4'hF, 0, 1'b0);
        xact(32'h0, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        chk("alias_load", 64'(last_rdata), 64'(32'h55));

        // Reset while in WAIT: no response, store committed at accept persists
        req_valid = 1'b1; req_addr = 32'h40; req_we = 1'b1;
        req_wdata = 32'h77; req_wstrb = 4'hF;
        @(posedge clk);
        model(32'h40, 1'b1, 32'h77, 4'hF, exp_d, exp_e);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("wait_rst_valid", 64'(rsp_valid), 64'(0));
        chk("wait_rst_ready", 64'(req_ready), 64'(1));
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("wait_rst_no_rsp", 64'(rsp_valid), 64'(0));
        end
        xact(32'h40, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        chk("persist_load", 64'(last_rdata), 64'(32'h77));

        // Fill a small working region so every later load has a known word
        for (int w = 0; w < 64; w++)
            xact(32'(w * 4), 1'b1, $urandom, 4'hF, 0, 1'b0);

`ifdef MEM_RESPONDER_MISALIGN_ERR_EN
        // Step 6: misaligned store suppressed and flagged
        xact(32'h20, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        exp_d = last_rdata;
        xact(32'h22, 1'b1, 32'h1, 4'hF, 0, 1'b0);
        chk("misalign_rdata", 64'(last_rdata), 64'(0));
        xact(32'h20, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        chk("misalign_unchanged", 64'(last_rdata), 64'(exp_d));
`endif

        // Random traffic over the working region with aliasing upper bits
        for (int i = 0; i < 150; i++) begin
            a = ($urandom << 12) | (32'($urandom_range(0, 63)) << 2);
            if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
            xact(a, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_mem_responder
